// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encodings, default
// timing parameters and a small state-classification helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_LAP    = 2'd3
  } sw_state_t;

  localparam int DEF_CLOCK_PERIOD    = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;

  // The prescaler advances and ticks are produced only in these states.
  function automatic logic is_counting(sw_state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Turns one raw asynchronous push button into a single-cycle press event:
// 2-FF synchronizer, stability-count debounce, registered rising-edge detect.
module btn_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any cycle that agrees with the accepted level restarts the count.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: conditions four buttons, runs the IDLE/RUN/PAUSED/LAP
// state machine and divides clk down to a one-cycle count tick.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLOCK_PERIOD    = DEF_CLOCK_PERIOD,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       lap,
  input  logic       clear,
  input  logic       at_max,
  output logic       tick,
  output logic       cnt_clr,
  output logic       disp_freeze,
  output logic [1:0] state,
  output logic       running
);

  localparam int PW = $clog2(CLOCK_PERIOD);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLOCK_PERIOD - 1);

  logic start_evt;
  logic pause_evt;
  logic lap_evt;
  logic clear_evt;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk(clk), .rst(rst), .raw(start), .press(start_evt)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
    .clk(clk), .rst(rst), .raw(pause), .press(pause_evt)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
    .clk(clk), .rst(rst), .raw(lap), .press(lap_evt)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .rst(rst), .raw(clear), .press(clear_evt)
  );

  sw_state_t     cur;
  sw_state_t     nxt;
  logic [PW-1:0] presc;
  logic          wrap_cycle;

  // A wrap cycle at the terminal count still wraps the prescaler but the
  // tick is swallowed so the counter chain never rolls past 59:59.
  assign wrap_cycle = is_counting(cur) && (presc == PRESC_LAST);
  assign tick       = wrap_cycle && !at_max;
  assign state      = cur;

  // Only the single highest-priority event is considered; if that one is
  // meaningless in the current state, the lower-priority ones are dropped.
  always_comb begin
    nxt = cur;
    if (clear_evt) begin
      nxt = ST_IDLE;
    end else if (wrap_cycle && at_max) begin
      nxt = ST_PAUSED;
    end else if (pause_evt) begin
      if (cur == ST_RUN || cur == ST_LAP) nxt = ST_PAUSED;
    end else if (start_evt) begin
      if (cur == ST_IDLE || cur == ST_PAUSED) nxt = ST_RUN;
    end else if (lap_evt) begin
      case (cur)
        ST_RUN:  nxt = ST_LAP;
        ST_LAP:  nxt = ST_RUN;
        default: nxt = cur;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur         <= ST_IDLE;
      presc       <= '0;
      cnt_clr     <= 1'b0;
      disp_freeze <= 1'b0;
      running     <= 1'b0;
    end else begin
      cur         <= nxt;
      cnt_clr     <= clear_evt;
      disp_freeze <= (nxt == ST_LAP);
      running     <= is_counting(nxt);
      // PAUSED keeps the fractional second; IDLE always restarts from zero.
      if (nxt == ST_IDLE) begin
        presc <= '0;
      end else if (is_counting(cur)) begin
        presc <= wrap_cycle ? '0 : presc + 1'b1;
      end
    end
  end

endmodule
